// File: rtl/decoder_pkg.sv
// decoder_pkg
//   Shared types and helpers for the one-hot decoder slice.
//   - dec_state_t : sequencer states (idle, direct decode, self-scan)
//   - dec_mode_t  : encoding of the mode input
//   - onehot_f / thermo_f : index -> one-hot / thermometer vectors.
//     Both return a DEC_MAX_W-wide vector; callers size-cast down to
//     their own output width, so any index width up to
//     $clog2(DEC_MAX_W) is supported.
package decoder_pkg;

   localparam int unsigned DEC_MAX_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIRECT,
      ST_SCAN
   } dec_state_t;

   typedef enum logic {
      MODE_DIRECT,
      MODE_SCAN
   } dec_mode_t;

   function automatic logic [DEC_MAX_W-1:0] onehot_f(input int unsigned idx);
      logic [DEC_MAX_W-1:0] v;
      for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
         v[i] = (i == idx);
      end
      return v;
   endfunction

   function automatic logic [DEC_MAX_W-1:0] thermo_f(input int unsigned idx);
      logic [DEC_MAX_W-1:0] v;
      for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
         v[i] = (i <= idx);
      end
      return v;
   endfunction

endpackage

// File: rtl/decoder_onehot_core.sv
// decoder_onehot_core
//   Purely combinational index decoder.
//   Ports:
//     idx     in   IN_W    binary index
//     onehot  out  OUT_W   1 << idx
//     thermo  out  OUT_W   (1 << (idx+1)) - 1   (only with DECODER_THERMO_EN)
//   Optional feature macro: DECODER_THERMO_EN
module decoder_onehot_core
   import decoder_pkg::*;
#(
   parameter  int unsigned IN_W  = 3,
   localparam int unsigned OUT_W = 1 << IN_W
) (
   input  logic [IN_W-1:0]  idx,
   output logic [OUT_W-1:0] onehot
`ifdef DECODER_THERMO_EN
  ,output logic [OUT_W-1:0] thermo
`endif
);

   assign onehot = OUT_W'(onehot_f(32'(idx)));

`ifdef DECODER_THERMO_EN
   assign thermo = OUT_W'(thermo_f(32'(idx)));
`endif

endmodule

// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq
//   Registered binary-to-one-hot decoder with valid/ready on both sides.
//   DIRECT mode decodes accepted input beats (1-deep, full throughput);
//   SCAN mode emits a walking one over all outputs, one beat every
//   SCAN_DIV cycles, stalling (never skipping) under backpressure.
//   Ports:
//     clk         in   1      clock, all logic on posedge
//     rst         in   1      synchronous active-high reset
//     mode        in   1      0 = DIRECT, 1 = SCAN (acted on from IDLE)
//     in_valid    in   1      input beat valid
//     in_ready    out  1      input beat accepted when in_valid && in_ready
//     in_data     in   IN_W   binary index
//     out_valid   out  1      output beat valid
//     out_ready   in   1      output beat taken when out_valid && out_ready
//     out_onehot  out  OUT_W  one-hot of out_idx while out_valid, else 0
//     out_idx     out  IN_W   binary index of the current beat
//     out_thermo  out  OUT_W  thermometer of out_idx while out_valid, else 0
//                             (present only with DECODER_THERMO_EN)
//   Optional feature macro: DECODER_THERMO_EN
module decoder_onehot_seq
   import decoder_pkg::*;
#(
   parameter  int unsigned IN_W     = 3,
   parameter  int unsigned SCAN_DIV = 4,
   localparam int unsigned OUT_W    = 1 << IN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic [IN_W-1:0]  out_idx
`ifdef DECODER_THERMO_EN
  ,output logic [OUT_W-1:0] out_thermo
`endif
);

   localparam int unsigned      DIV_W  = $clog2(SCAN_DIV + 1);
   localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);

   dec_state_t       state;
   dec_mode_t        mode_e;
   logic [DIV_W-1:0] div;
   logic [IN_W-1:0]  scan_idx;
   logic [IN_W-1:0]  sel_idx;
   logic [OUT_W-1:0] sel_onehot;
   logic             drain_ok;
   logic             accept;
`ifdef DECODER_THERMO_EN
   logic [OUT_W-1:0] sel_thermo;
`endif

   assign mode_e = dec_mode_t'(mode);

   // The output register is free next cycle if empty or being drained now.
   assign drain_ok = !out_valid || out_ready;

   // A pending mode change to SCAN closes the input so the register can
   // drain and the switch to IDLE never drops a freshly accepted beat.
   assign in_ready = (state == ST_DIRECT) && (mode_e == MODE_DIRECT) && drain_ok;
   assign accept   = in_valid && in_ready;

   assign sel_idx  = (state == ST_SCAN) ? scan_idx : in_data;

   decoder_onehot_core #(
      .IN_W (IN_W)
   ) u_core (
      .idx    (sel_idx),
      .onehot (sel_onehot)
`ifdef DECODER_THERMO_EN
     ,.thermo (sel_thermo)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         out_valid  <= 1'b0;
         out_onehot <= '0;
         out_idx    <= '0;
         div        <= '0;
         scan_idx   <= '0;
`ifdef DECODER_THERMO_EN
         out_thermo <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= (mode_e == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
               div      <= '0;
               scan_idx <= '0;
            end

            ST_DIRECT: begin
               if (accept) begin
                  out_valid  <= 1'b1;
                  out_onehot <= sel_onehot;
                  out_idx    <= sel_idx;
`ifdef DECODER_THERMO_EN
                  out_thermo <= sel_thermo;
`endif
               end else if (out_ready) begin
                  out_valid  <= 1'b0;
                  out_onehot <= '0;
`ifdef DECODER_THERMO_EN
                  out_thermo <= '0;
`endif
               end
               if ((mode_e == MODE_SCAN) && drain_ok) begin
                  state <= ST_IDLE;
               end
            end

            ST_SCAN: begin
               if ((mode_e == MODE_DIRECT) && drain_ok) begin
                  state      <= ST_IDLE;
                  out_valid  <= 1'b0;
                  out_onehot <= '0;
                  div        <= '0;
                  scan_idx   <= '0;
`ifdef DECODER_THERMO_EN
                  out_thermo <= '0;
`endif
               end else if (div != DIV_TC) begin
                  div <= div + 1'b1;
                  if (out_ready) begin
                     out_valid  <= 1'b0;
                     out_onehot <= '0;
`ifdef DECODER_THERMO_EN
                     out_thermo <= '0;
`endif
                  end
               end else if (drain_ok) begin
                  // Terminal count with a free register: emit and advance.
                  out_valid  <= 1'b1;
                  out_onehot <= sel_onehot;
                  out_idx    <= sel_idx;
                  scan_idx   <= scan_idx + 1'b1;
                  div        <= '0;
`ifdef DECODER_THERMO_EN
                  out_thermo <= sel_thermo;
`endif
               end
               // Terminal count with a stalled beat: hold everything.
            end

            default: begin
               state      <= ST_IDLE;
               out_valid  <= 1'b0;
               out_onehot <= '0;
`ifdef DECODER_THERMO_EN
               out_thermo <= '0;
`endif
            end
         endcase
      end
   end

endmodule
